// File: rtl/word_bus_arbiter.sv
// Two-requester round-robin arbiter for a shared word path.
// One owner at a time. Ownership ends on i_done or after MAX_HOLD owned
// cycles (watchdog). At least one idle cycle always separates two grants.
module word_bus_arbiter #(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req0,
  input  logic [0:WIDTH-1] i_val0,
  input  logic             i_req1,
  input  logic [0:WIDTH-1] i_val1,
  input  logic             i_done,
  output logic             o_gnt0,
  output logic             o_gnt1,
  output logic             o_sel,
  output logic [0:WIDTH-1] o_val,
  output logic             o_busy,
  output logic             o_err
);

  localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             last, last_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sel_nxt;
  logic [0:WIDTH-1] val_nxt;
  logic             err_nxt;

  // State, arbitration history, watchdog counter and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
      o_sel <= 1'b0;
      o_val <= '0;
      o_err <= 1'b0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
      o_sel <= sel_nxt;
      o_val <= val_nxt;
      o_err <= err_nxt;
    end
  end

  // Next-state: round-robin grant from IDLE, release on done or watchdog
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    sel_nxt   = o_sel;
    val_nxt   = o_val;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        // Requester 0 wins when alone or when requester 1 was served last
        if (i_req0 && (!i_req1 || last)) begin
          state_nxt = OWN0;
          cnt_nxt   = '0;
          sel_nxt   = 1'b0;
          val_nxt   = i_val0;
        end else if (i_req1) begin
          state_nxt = OWN1;
          cnt_nxt   = '0;
          sel_nxt   = 1'b1;
          val_nxt   = i_val1;
        end
      end
      OWN0, OWN1: begin
        // done takes priority over the watchdog on the final allowed cycle
        if (i_done) begin
          state_nxt = IDLE;
          last_nxt  = (state == OWN1);
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          last_nxt  = (state == OWN1);
          err_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign o_gnt0 = (state == OWN0);
  assign o_gnt1 = (state == OWN1);
  assign o_busy = o_gnt0 | o_gnt1;

endmodule

// File: tb/tb_word_bus_arbiter.sv
// Directed testbench for word_bus_arbiter (WIDTH=16, MAX_HOLD=8).
// Inputs change 1 time unit after each rising edge; outputs are checked
// at that same point, i.e. the value registered by the preceding edge.
module tb_word_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, done;
  logic [0:15] val0, val1;
  logic        gnt0, gnt1, sel, busy, err;
  logic [0:15] val;

  int checks   = 0;
  int failures = 0;

  word_bus_arbiter #(.WIDTH(16), .MAX_HOLD(8)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_req0(req0),
    .i_val0(val0),
    .i_req1(req1),
    .i_val1(val1),
    .i_done(done),
    .o_gnt0(gnt0),
    .o_gnt1(gnt1),
    .o_sel (sel),
    .o_val (val),
    .o_busy(busy),
    .o_err (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_out(input string tag, input logic g0, input logic g1, input logic s,
                         input logic [15:0] v, input logic e);
    chk({tag, "_gnt0"}, {31'd0, gnt0}, {31'd0, g0});
    chk({tag, "_gnt1"}, {31'd0, gnt1}, {31'd0, g1});
    chk({tag, "_sel"},  {31'd0, sel},  {31'd0, s});
    chk({tag, "_val"},  {16'd0, val},  {16'd0, v});
    chk({tag, "_busy"}, {31'd0, busy}, {31'd0, g0 | g1});
    chk({tag, "_err"},  {31'd0, err},  {31'd0, e});
  endtask

  initial begin
    // 1: reset with both requests high, then requester 0 wins first
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; done = 1'b0;
    val0 = 16'hAAAA; val1 = 16'h5555;
    tick(); tick();
    chk_out("t1_rst", 0, 0, 0, 16'h0000, 0);
    rst = 1'b0;
    tick();
    chk_out("t1_first", 1, 0, 0, 16'hAAAA, 0);
    done = 1'b1; req0 = 1'b0; req1 = 1'b0;
    tick();
    chk_out("t1_rel", 0, 0, 0, 16'hAAAA, 0);
    done = 1'b0;

    // 2: only requester 1, release by done three cycles later
    req1 = 1'b1; val1 = 16'h1234;
    tick();
    chk_out("t2_gnt", 0, 1, 1, 16'h1234, 0);
    req1 = 1'b0; val1 = 16'h0000;
    tick(); tick();
    chk_out("t2_hold", 0, 1, 1, 16'h1234, 0);
    done = 1'b1;
    tick();
    chk_out("t2_rel", 0, 0, 1, 16'h1234, 0);
    // done while idle has no effect
    tick();
    chk_out("t2_idle_done", 0, 0, 1, 16'h1234, 0);
    done = 1'b0;

    // 3: both requests held, done on 2nd owned cycle -> 0,1,0,1 with one idle cycle between
    req0 = 1'b1; req1 = 1'b1; val0 = 16'h0001; val1 = 16'h0002;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("t3_own_a", (i % 2) == 0, (i % 2) == 1, (i % 2) == 1,
              ((i % 2) == 0) ? 16'h0001 : 16'h0002, 0);
      tick();
      chk_out("t3_own_b", (i % 2) == 0, (i % 2) == 1, (i % 2) == 1,
              ((i % 2) == 0) ? 16'h0001 : 16'h0002, 0);
      done = 1'b1;
      tick();
      chk_out("t3_gap", 0, 0, (i % 2) == 1, ((i % 2) == 0) ? 16'h0001 : 16'h0002, 0);
      done = 1'b0;
    end
    req0 = 1'b0; req1 = 1'b0;

    // 4: watchdog - grant lasts exactly 8 cycles, one-cycle err, then pending req1 granted
    req0 = 1'b1; val0 = 16'h00C3;
    tick();
    chk_out("t4_c1", 1, 0, 0, 16'h00C3, 0);
    req0 = 1'b0; req1 = 1'b1; val1 = 16'h0BEE;
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk_out("t4_hold", 1, 0, 0, 16'h00C3, 0);
    end
    tick();
    chk_out("t4_timeout", 0, 0, 0, 16'h00C3, 1);
    tick();
    chk_out("t4_next", 0, 1, 1, 16'h0BEE, 0);
    req1 = 1'b0; done = 1'b1;
    tick();
    chk_out("t4_rel", 0, 0, 1, 16'h0BEE, 0);
    done = 1'b0;

    // 5: owner word is captured once; later i_val0 changes and dropped request are ignored
    req0 = 1'b1; val0 = 16'h00FF;
    tick();
    chk_out("t5_gnt", 1, 0, 0, 16'h00FF, 0);
    val0 = 16'hFF00; req0 = 1'b0;
    tick();
    chk_out("t5_hold1", 1, 0, 0, 16'h00FF, 0);
    tick();
    chk_out("t5_hold2", 1, 0, 0, 16'h00FF, 0);
    done = 1'b1;
    tick();
    chk_out("t5_rel", 0, 0, 0, 16'h00FF, 0);
    done = 1'b0;

    // 6: reset in 3rd cycle of OWN1, then req0 wins; done on 8th owned cycle is a clean release
    req1 = 1'b1; val1 = 16'hBEEF;
    tick();
    chk_out("t6_gnt1", 0, 1, 1, 16'hBEEF, 0);
    req1 = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk_out("t6_rst", 0, 0, 0, 16'h0000, 0);
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
    tick();
    chk_out("t6_gnt0", 1, 0, 0, 16'hFF00, 0);
    req0 = 1'b0; req1 = 1'b0;
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk_out("t6_hold", 1, 0, 0, 16'hFF00, 0);
    end
    done = 1'b1;
    tick();
    chk_out("t6_rel", 0, 0, 0, 16'hFF00, 0);
    done = 1'b0;
    tick();
    chk_out("t6_noerr", 0, 0, 0, 16'hFF00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
